// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR step sequencer.
//   NBITS_DEF          default LFSR width
//   TAP_A/TAP_B/TAP_C  1-based feedback tap positions of the Fibonacci LFSR
//   state_e            controller FSM states
//   lfsr_next()        one shift of the reference LFSR (used by models of the datapath)
package lfsr_pkg;

  localparam int NBITS_DEF = 16;

  localparam int TAP_A = 12;
  localparam int TAP_B = 3;
  localparam int TAP_C = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WAIT,
    DONE
  } state_e;

  // Shift left, feedback from the three taps enters at bit 0.
  function automatic logic [NBITS_DEF-1:0] lfsr_next(input logic [NBITS_DEF-1:0] q);
    return {q[NBITS_DEF-2:0], q[TAP_A-1] ^ q[TAP_B-1] ^ q[TAP_C-1]};
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Bundle between requesters, the LFSR datapath, the result consumer and the sequencer.
//   req/req_seed/req_len   requester side (packed per requester)
//   gnt                    one-hot grant pulse
//   lfsr_load/seed/step/q  datapath control and registered state
//   done_valid/id/q/ready  result handshake
//   busy                   sequencer not idle
// slave is the sequencer view, master the surrounding environment.
interface lfsr_seq_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 16,
  parameter int LENW  = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] req_seed;
  logic [NREQ*LENW-1:0]  req_len;
  logic [NREQ-1:0]       gnt;
  logic                  lfsr_load;
  logic [NBITS-1:0]      lfsr_seed;
  logic                  lfsr_step;
  logic [NBITS-1:0]      lfsr_q;
  logic                  done_valid;
  logic [IW-1:0]         done_id;
  logic [NBITS-1:0]      done_q;
  logic                  done_ready;
  logic                  busy;

  modport slave (
    input  req, req_seed, req_len, lfsr_q, done_ready,
    output gnt, lfsr_load, lfsr_seed, lfsr_step, done_valid, done_id, done_q, busy
  );

  modport master (
    output req, req_seed, req_len, lfsr_q, done_ready,
    input  gnt, lfsr_load, lfsr_seed, lfsr_step, done_valid, done_id, done_q, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i  request vector
//   ptr_i  index with highest priority this round
//   gnt_o  one-hot grant (zero when no request)
//   idx_o  encoded index of the granted requester
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    // Scan from the pointer upwards, wrapping modulo NREQ; first hit wins.
    for (int off = 0; off < NREQ; off++) begin
      cand = IW'((int'(ptr_i) + off) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Shares one external LFSR datapath between NREQ requesters. A round-robin winner's
// seed is loaded, exactly len step pulses are issued, and the resulting LFSR value is
// returned tagged with the requester id over a valid/ready handshake.
//   clk, rst  clock and asynchronous active-low reset
//   bus       lfsr_seq_ctrl_if.slave (requests, datapath control, result, busy)
// Parameters must match those of the connected interface instance.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = NBITS_DEF,
  parameter int LENW  = 8
) (
  input logic            clk,
  input logic            rst,
  lfsr_seq_ctrl_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_e           state_q;
  logic [IW-1:0]    rr_q;
  logic [IW-1:0]    win_q;
  logic [NBITS-1:0] seed_q;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  cnt_q;
  logic [NREQ-1:0]  gnt_q;
  logic             load_q;
  logic [NBITS-1:0] lfsr_seed_q;
  logic             step_q;
  logic             done_valid_q;
  logic [IW-1:0]    done_id_q;
  logic [NBITS-1:0] done_q_q;

  logic [NBITS-1:0] seed_arr [NREQ];
  logic [LENW-1:0]  len_arr  [NREQ];
  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;

  // Unpack the per-requester fields so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      seed_arr[i] = bus.req_seed[i*NBITS +: NBITS];
      len_arr[i]  = bus.req_len[i*LENW +: LENW];
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (bus.req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      win_q        <= '0;
      seed_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      load_q       <= 1'b0;
      lfsr_seed_q  <= '0;
      step_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_q_q     <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      gnt_q  <= '0;
      load_q <= 1'b0;
      step_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            gnt_q   <= arb_gnt;
            win_q   <= arb_idx;
            seed_q  <= seed_arr[arb_idx];
            len_q   <= len_arr[arb_idx];
            state_q <= LOAD;
          end
        end
        LOAD: begin
          load_q      <= 1'b1;
          lfsr_seed_q <= seed_q;
          cnt_q       <= len_q;
          state_q     <= (len_q == '0) ? DONE : RUN;
        end
        RUN: begin
          // Counter only runs down from len to 1, so len=255 cannot wrap.
          step_q <= 1'b1;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == LENW'(1)) state_q <= WAIT;
        end
        WAIT: begin
          // Last step pulse is on the wire now; lfsr_q settles before DONE samples it.
          state_q <= DONE;
        end
        DONE: begin
          if (!done_valid_q) begin
            done_valid_q <= 1'b1;
            done_id_q    <= win_q;
            // With len=0 the datapath is still loading this cycle, so take the seed directly.
            done_q_q     <= (len_q == '0) ? seed_q : bus.lfsr_q;
          end else if (bus.done_ready) begin
            done_valid_q <= 1'b0;
            rr_q         <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.lfsr_load  = load_q;
  assign bus.lfsr_seed  = lfsr_seed_q;
  assign bus.lfsr_step  = step_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_q     = done_q_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Sequencer/arbiter that shares one 16-bit Fibonacci LFSR datapath (taps d[12]^d[3]^d[1], 1-based) between NREQ requesters.
- Each request supplies a seed and a shift count. The block grants one requester round-robin, loads the seed, issues exactly that many step pulses, then returns the LFSR value tagged with the requester id.
- Sits in the CRC top level between the replay-buffer clients and the LFSR datapath. It replaces that datapath's free-running 15-step behaviour with explicit, counted stepping.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBITS, 16, LFSR width.
- LENW, 8, width of the shift-count field (max 255 steps).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held until granted.
- req_seed  in  NREQ*NBITS  packed seeds, requester i at [i*NBITS +: NBITS].
- req_len  in  NREQ*LENW  packed step counts, requester i at [i*LENW +: LENW].
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- lfsr_load  out  1  load strobe to datapath.
- lfsr_seed  out  NBITS  seed driven with lfsr_load.
- lfsr_step  out  1  one shift per cycle while high.
- lfsr_q  in  NBITS  current LFSR state, registered in the datapath.
- done_valid  out  1  result available.
- done_id  out  $clog2(NREQ)  requester index of the result.
- done_q  out  NBITS  captured LFSR value.
- done_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; gnt=0; lfsr_load=0; lfsr_step=0; lfsr_seed=0; done_valid=0; done_id=0; done_q=0; busy=0; rr pointer=0; step counter=0.
- FSM states:
  - IDLE: if any req, the arbiter picks the first set bit at or after the rr pointer, wrapping modulo NREQ. In that cycle: gnt pulses one-hot, seed and len are captured into registers, and the FSM moves to LOAD. No req → stay in IDLE.
  - LOAD (1 cycle): lfsr_load=1, lfsr_seed=captured seed. Next state is RUN if len!=0, else DONE. Counter=len.
  - RUN: lfsr_step=1 every cycle; counter decrements. When counter==1 and a step is issued, move to WAIT.
  - WAIT (1 cycle): lfsr_step=0; gives the datapath one cycle to settle its registered q. Then move to DONE.
  - DONE: done_q captured from lfsr_q on entry. done_valid=1; done_id and done_q held stable until done_ready=1. On done_valid&&done_ready: done_valid drops next cycle, rr pointer = winner+1 mod NREQ, state=IDLE.
- Latency:
  - Grant in cycle T, load in T+1, steps in T+2..T+1+len.
  - done_valid rises at T+3+len (len>0) or T+2 (len=0).
  - Minimum gap between consecutive grants is 1 IDLE cycle.
- Outputs:
  - gnt is registered; asserted only in the IDLE→LOAD transition cycle.
  - lfsr_load and lfsr_step are never high together.
- Requester rules:
  - Requesters must hold req, seed and len stable until gnt. Values are sampled only on grant.
  - Dropping req before grant is legal; the requester is simply not selected.
- Boundary conditions:
  - All req set: strict rotation 0,1,2,3,0,...
  - Single requester: it is re-granted back-to-back after each DONE handshake.
  - len=0: done_q equals the seed.
  - len=2^LENW-1: counter must not wrap.
  - done_ready held high before DONE: completes in the first DONE cycle.
- Reset mid-operation (any state): immediate return to reset values, with no step pulse issued after reset assertion. The rr pointer also resets to 0.

Decomposition:
- Package lfsr_pkg:
  - NBITS default.
  - Tap constants TAP_A=12, TAP_B=3, TAP_C=1.
  - FSM state enum {IDLE, LOAD, RUN, WAIT, DONE}.
  - A reference next-state function, for bench use.
- Sub-module rr_arbiter (NREQ): inputs req and pointer; outputs one-hot grant and encoded index; purely combinational. The rest of the controller stays in lfsr_seq_ctrl.

Test Plan:
- Req0 only, seed 0x0001, len 3, done_ready=1 → gnt=0001 at T; lfsr_load at T+1; 3 step pulses; done_valid at T+6 with done_id=0, done_q=0x000E (0x0001→0x0003→0x0007→0x000E).
- Req2, seed 0xACE1, len 0 → no step pulses; done_valid at T+2, done_q=0xACE1, done_id=2.
- req=1111 held, len 1 each, done_ready=1 → grant order 0,1,2,3,0; each done_id matches.
- Req1, seed 0x0001, len 2, done_ready=0 for 5 cycles, then 1 → done_valid and done_q=0x0007 stay stable; next grant only after the handshake.
- Reset pulse during RUN of a len-200 request → all outputs 0 asynchronously; after release, req3 is granted with the rr pointer starting from 0.
- len 255 with seed 0x0001 → exactly 255 step pulses counted; done_q matches the package reference function.
